subckt_bist_sequencer: RTL

- Built-in self-test controller for the netlist-level DFF subcircuits: drives pseudo-random patterns onto the subcircuit data inputs and compacts its registered output into a signature.
- Runs a fixed sequence: flush the DUT, apply N patterns, drain the pipeline, then compare the signature against a golden value and report pass/fail.
- Sits beside each subcircuit instance in the detection harness. A signature mismatch flags a structurally altered subcircuit.

---
 rtl/subckt_bist_pkg.sv | 27 ++
 rtl/bist_misr16.sv | 33 +++
 rtl/subckt_bist_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/subckt_bist_pkg.sv
// Shared constants for the subcircuit BIST sequencer: FSM encodings,
// polynomial taps, default seed and flush length.
package subckt_bist_pkg;

   localparam int unsigned SIG_W     = 16;
   localparam int unsigned ST_W      = 3;
   localparam int unsigned FLUSH_LEN = 2;

   localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [ST_W-1:0] ST_FLUSH   = 3'd1;
   localparam logic [ST_W-1:0] ST_APPLY   = 3'd2;
   localparam logic [ST_W-1:0] ST_DRAIN   = 3'd3;
   localparam logic [ST_W-1:0] ST_COMPARE = 3'd4;
   localparam logic [ST_W-1:0] ST_DONE    = 3'd5;

   // x^16 + x^14 + x^13 + x^11 + 1 : feedback from bits 15, 13, 12, 10
   localparam logic [SIG_W-1:0] LFSR_TAPS    = 16'hB400;
   localparam logic [SIG_W-1:0] MISR_TAPS    = 16'hB400;
   localparam logic [SIG_W-1:0] DEFAULT_SEED = 16'hACE1;

   // One left-shift step of a Fibonacci register with the given tap mask
   function automatic logic [SIG_W-1:0] poly_step(input logic [SIG_W-1:0] v,
                                                  input logic [SIG_W-1:0] taps);
      return {v[SIG_W-2:0], ^(v & taps)};
   endfunction

endpackage

// File: rtl/bist_misr16.sv
// 16-bit serial-input MISR with synchronous clear and update enable.
module bist_misr16
   import subckt_bist_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [SIG_W-1:0] sig,
   output logic [SIG_W-1:0] sig_nxt_c
);

   // Next signature: clear wins over compaction
   always_comb begin
      sig_nxt_c = sig;
      if (clr) begin
         sig_nxt_c = '0;
      end else if (en) begin
         sig_nxt_c = poly_step(sig, MISR_TAPS) ^ {{(SIG_W-1){1'b0}}, din};
      end
   end

   // Signature register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig <= '0;
      end else begin
         sig <= sig_nxt_c;
      end
   end

endmodule

// File: rtl/subckt_bist_sequencer.sv
// BIST controller for a netlist-level DFF subcircuit: flush, apply LFSR
// patterns, drain the subcircuit pipeline, compare the MISR signature.
module subckt_bist_sequencer
   import subckt_bist_pkg::*;
#(
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned LAT    = 3,
   parameter int unsigned CNT_W  = 16
)(
   input  logic              I1470,
   input  logic              I1477,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_vec,
   input  logic [SIG_W-1:0]  seed,
   input  logic [SIG_W-1:0]  golden_sig,
   output logic              dut_rst,
   output logic [NUM_IN-1:0] pat_out,
   input  logic              dut_resp,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [SIG_W-1:0]  signature
);

   localparam int unsigned TMR_W = 4;

   logic [ST_W-1:0]  state;
   logic [ST_W-1:0]  state_nxt;
   logic [CNT_W-1:0] nv_q;
   logic [CNT_W-1:0] cnt;
   logic [SIG_W-1:0] golden_q;
   logic [SIG_W-1:0] lfsr;
   logic [TMR_W-1:0] tmr;
   // [0] marks a pattern on pat_out; [LAT] marks its response on dut_resp
   logic [LAT:0]     vpipe;
   logic [SIG_W-1:0] sig_nxt;
   logic             accept;
   logic             last_vec;
   logic             flush_end;
   logic             drain_end;

   assign accept    = (state == ST_IDLE) && start;
   // Widened compare so num_vec = 2^CNT_W-1 terminates without wrap
   assign last_vec  = ({1'b0, cnt} + (CNT_W+1)'(1)) == {1'b0, nv_q};
   assign flush_end = (tmr == TMR_W'(FLUSH_LEN - 1));
   assign drain_end = (tmr == TMR_W'(LAT - 1));

   // State register
   always_ff @(posedge I1470 or posedge I1477) begin
      if (I1477) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; num_vec = 0 skips APPLY but still drains
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (start) state_nxt = ST_FLUSH;
         ST_FLUSH:   if (flush_end) state_nxt = (nv_q == '0) ? ST_DRAIN : ST_APPLY;
         ST_APPLY:   if (last_vec) state_nxt = ST_DRAIN;
         ST_DRAIN:   if (drain_end) state_nxt = ST_COMPARE;
         ST_COMPARE: state_nxt = ST_DONE;
         ST_DONE:    state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Phase timer for FLUSH and DRAIN, restarted on every state change
   always_ff @(posedge I1470 or posedge I1477) begin
      if (I1477) begin
         tmr <= '0;
      end else if (state_nxt != state) begin
         tmr <= '0;
      end else if ((state == ST_FLUSH) || (state == ST_DRAIN)) begin
         tmr <= tmr + TMR_W'(1);
      end
   end

   // Test parameters, pattern generator and vector counter
   always_ff @(posedge I1470 or posedge I1477) begin
      if (I1477) begin
         nv_q     <= '0;
         golden_q <= '0;
         lfsr     <= '0;
         cnt      <= '0;
      end else if (accept) begin
         nv_q     <= num_vec;
         golden_q <= golden_sig;
         lfsr     <= (seed == '0) ? DEFAULT_SEED : seed;
         cnt      <= '0;
      end else if (state == ST_APPLY) begin
         lfsr     <= poly_step(lfsr, LFSR_TAPS);
         cnt      <= cnt + CNT_W'(1);
      end
   end

   // Pattern register and response-valid pipe
   always_ff @(posedge I1470 or posedge I1477) begin
      if (I1477) begin
         pat_out <= '0;
         vpipe   <= '0;
      end else begin
         pat_out <= (state == ST_APPLY) ? lfsr[NUM_IN-1:0] : '0;
         if (accept) begin
            vpipe <= '0;
         end else if (state != ST_IDLE) begin
            vpipe <= {vpipe[LAT-1:0], (state == ST_APPLY)};
         end
      end
   end

   // Registered status outputs, decoded from the upcoming state
   always_ff @(posedge I1470 or posedge I1477) begin
      if (I1477) begin
         dut_rst <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pass    <= 1'b0;
      end else begin
         dut_rst <= (state_nxt == ST_FLUSH);
         busy    <= (state_nxt == ST_FLUSH) || (state_nxt == ST_APPLY) ||
                    (state_nxt == ST_DRAIN) || (state_nxt == ST_COMPARE);
         done    <= (state_nxt == ST_DONE);
         // The final response is compacted during COMPARE, so judge the next signature
         if (accept) begin
            pass <= 1'b0;
         end else if (state == ST_COMPARE) begin
            pass <= (sig_nxt == golden_q);
         end
      end
   end

   bist_misr16 u_misr (
      .clk       (I1470),
      .rst       (I1477),
      .clr       (accept),
      .en        (vpipe[LAT]),
      .din       (dut_resp),
      .sig       (signature),
      .sig_nxt_c (sig_nxt)
   );

endmodule
